// File: rtl/vault_lock.sv
// Keypad vault controller: synchronised key input, N-digit entry buffer, stored password,
// failed-attempt counter. Timed lockout is built only when VAULT_LOCKOUT_EN is defined.
module vault_lock #(
    parameter int N_DIGITS       = 6,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 50_000_000
) (
    input  logic                          MAX10_CLK1_50,
    input  logic                          reset,
    input  logic                          key_valid,
    input  logic [3:0]                    key_code,
    output logic [1:0]                    state_o,
    output logic                          unlocked,
    output logic [4*N_DIGITS-1:0]         entry_digits,
    output logic [$clog2(N_DIGITS+1)-1:0] entry_count,
    output logic [3:0]                    fail_count,
    output logic                          lockout_active,
    output logic                          pass_ok,
    output logic                          pass_bad
);

    localparam int BW = 4 * N_DIGITS;
    localparam int CW = $clog2(N_DIGITS + 1);

    localparam logic [1:0] ST_OPEN   = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;

    localparam logic [3:0]    KEY_ENTER  = 4'hE;
    localparam logic [3:0]    KEY_CANCEL = 4'hF;
    localparam logic [CW-1:0] CNT_FULL   = CW'(N_DIGITS);

    if (N_DIGITS < 1 || N_DIGITS > 8 || MAX_FAILS < 1 || MAX_FAILS > 15 || LOCKOUT_CYCLES < 1)
    begin : g_param_check
        $error("vault_lock: parameter out of legal range");
    end

`ifdef VAULT_LOCKOUT_EN
    localparam logic [1:0]    ST_LOCKOUT = 2'd2;
    localparam int            TW         = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]    FAIL_LIMIT = 4'(MAX_FAILS);

    logic [TW-1:0] timer_q, timer_d;
    logic          lockout_q;
`endif

    logic          valid_s1_q, valid_s2_q, valid_prev_q;
    logic [3:0]    code_s1_q, code_s2_q;
    logic [1:0]    state_q, state_d;
    logic [BW-1:0] pwd_q, pwd_d;
    logic [BW-1:0] buf_q, buf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    fail_q, fail_d;
    logic [3:0]    fail_inc;
    logic          ok_q, ok_d;
    logic          bad_q, bad_d;
    logic          unlocked_q;
    logic          key_evt, key_enter, key_cancel, entry_full;

    assign key_evt    = valid_s2_q & ~valid_prev_q;
    assign key_enter  = (code_s2_q == KEY_ENTER);
    assign key_cancel = (code_s2_q == KEY_CANCEL);
    assign entry_full = (cnt_q == CNT_FULL);
    assign fail_inc   = fail_q + 4'd1;

    always_comb begin
        state_d = state_q;
        pwd_d   = pwd_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        ok_d    = 1'b0;
        bad_d   = 1'b0;
`ifdef VAULT_LOCKOUT_EN
        timer_d = timer_q;
`endif
        case (state_q)
            ST_OPEN, ST_LOCKED: begin
                if (key_evt) begin
                    if (key_cancel) begin
                        buf_d = '0;
                        cnt_d = '0;
                    end else if (key_enter) begin
                        if (state_q == ST_OPEN) begin
                            // A short entry in OPEN is ignored and the buffer kept.
                            if (entry_full) begin
                                pwd_d   = buf_q;
                                buf_d   = '0;
                                cnt_d   = '0;
                                state_d = ST_LOCKED;
                            end
                        end else begin
                            buf_d = '0;
                            cnt_d = '0;
                            if (entry_full && (buf_q == pwd_q)) begin
                                ok_d    = 1'b1;
                                fail_d  = '0;
                                state_d = ST_OPEN;
                            end else begin
                                bad_d = 1'b1;
`ifdef VAULT_LOCKOUT_EN
                                if (fail_inc == FAIL_LIMIT) begin
                                    fail_d  = '0;
                                    timer_d = TIMER_LOAD;
                                    state_d = ST_LOCKOUT;
                                end else begin
                                    fail_d = fail_inc;
                                end
`else
                                if (fail_q != 4'hF) begin
                                    fail_d = fail_inc;
                                end
`endif
                            end
                        end
                    end else if (!entry_full) begin
                        buf_d = (buf_q << 4) | BW'(code_s2_q);
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef VAULT_LOCKOUT_EN
            ST_LOCKOUT: begin
                // Key events are dropped here, including one coinciding with expiry.
                buf_d = '0;
                cnt_d = '0;
                if (timer_q == '0) begin
                    state_d = ST_LOCKED;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_OPEN;
                buf_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            valid_s1_q   <= 1'b0;
            valid_s2_q   <= 1'b0;
            valid_prev_q <= 1'b0;
            code_s1_q    <= '0;
            code_s2_q    <= '0;
            state_q      <= ST_OPEN;
            pwd_q        <= '0;
            buf_q        <= '0;
            cnt_q        <= '0;
            fail_q       <= '0;
            ok_q         <= 1'b0;
            bad_q        <= 1'b0;
            unlocked_q   <= 1'b1;
`ifdef VAULT_LOCKOUT_EN
            timer_q      <= '0;
            lockout_q    <= 1'b0;
`endif
        end else begin
            valid_s1_q   <= key_valid;
            valid_s2_q   <= valid_s1_q;
            valid_prev_q <= valid_s2_q;
            code_s1_q    <= key_code;
            code_s2_q    <= code_s1_q;
            state_q      <= state_d;
            pwd_q        <= pwd_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            fail_q       <= fail_d;
            ok_q         <= ok_d;
            bad_q        <= bad_d;
            unlocked_q   <= (state_d == ST_OPEN);
`ifdef VAULT_LOCKOUT_EN
            timer_q      <= timer_d;
            lockout_q    <= (state_d == ST_LOCKOUT);
`endif
        end
    end

    assign state_o      = state_q;
    assign unlocked     = unlocked_q;
    assign entry_digits = buf_q;
    assign entry_count  = cnt_q;
    assign fail_count   = fail_q;
    assign pass_ok      = ok_q;
    assign pass_bad     = bad_q;
`ifdef VAULT_LOCKOUT_EN
    assign lockout_active = lockout_q;
`else
    assign lockout_active = 1'b0;
`endif

endmodule

// File: tb/tb_vault_lock.sv
// Bench for vault_lock: directed scenarios plus random key sequences, checked every cycle
// against a digit-queue model of the vault; follows VAULT_LOCKOUT_EN like the design.
`timescale 1ns/1ps
module tb_vault_lock;

    localparam int N    = 4;
    localparam int MAXF = 3;
    localparam int LOCK = 20;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_valid;
    logic [3:0]   key_code;
    logic [1:0]   state_o;
    logic         unlocked;
    logic [4*N-1:0] entry_digits;
    logic [2:0]   entry_count;
    logic [3:0]   fail_count;
    logic         lockout_active;
    logic         pass_ok;
    logic         pass_bad;

    always #5 clk = ~clk;

    vault_lock #(.N_DIGITS(N), .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCK)) dut (
        .MAX10_CLK1_50 (clk),
        .reset         (reset),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .state_o       (state_o),
        .unlocked      (unlocked),
        .entry_digits  (entry_digits),
        .entry_count   (entry_count),
        .fail_count    (fail_count),
        .lockout_active(lockout_active),
        .pass_ok       (pass_ok),
        .pass_bad      (pass_bad)
    );

    typedef struct {
        int unsigned due;
        logic [3:0]  code;
    } ev_t;

    int          n_checks = 0;
    int          n_err    = 0;
    int          n_ok_seen = 0, n_bad_seen = 0, n_lock_seen = 0;
    int unsigned cyc = 0;
    bit          m_live = 0;
    ev_t         evq[$];

    // Vault model: mode 0=open 1=locked 2=lockout, entry as a queue of digits (oldest first).
    int          m_mode;
    int          m_digits[$];
    logic [31:0] m_pwd;
    int          m_fails;
    int          m_lock_left;
    bit          m_ok, m_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_value();
        logic [31:0] v;
        v = '0;
        foreach (m_digits[i]) v = (v << 4) | 32'(m_digits[i]);
        return v;
    endfunction

    function automatic void model_reset();
        m_mode = 0;
        m_digits.delete();
        m_pwd = '0;
        m_fails = 0;
        m_lock_left = 0;
        m_ok = 0;
        m_bad = 0;
    endfunction

    function automatic void model_key(input logic [3:0] c);
        bit good;
        if (c == 4'hF) begin
            m_digits.delete();
        end else if (c == 4'hE) begin
            if (m_mode == 0) begin
                if (m_digits.size() == N) begin
                    m_pwd = m_value();
                    m_digits.delete();
                    m_mode = 1;
                end
            end else begin
                good = (m_digits.size() == N) && (m_value() == m_pwd);
                m_digits.delete();
                if (good) begin
                    m_ok = 1;
                    m_fails = 0;
                    m_mode = 0;
                end else begin
                    m_bad = 1;
`ifdef VAULT_LOCKOUT_EN
                    m_fails++;
                    if (m_fails == MAXF) begin
                        m_fails = 0;
                        m_mode = 2;
                        m_lock_left = LOCK;
                    end
`else
                    if (m_fails < 15) m_fails++;
`endif
                end
            end
        end else if (m_digits.size() < N) begin
            m_digits.push_back(int'(c));
        end
    endfunction

    always @(posedge clk) begin
        ev_t ev;
        bit  have_ev;
        cyc++;
        have_ev = 0;
        if (evq.size() > 0 && evq[0].due == cyc) begin
            ev = evq.pop_front();
            have_ev = 1;
        end
        m_ok = 0;
        m_bad = 0;
        if (reset) begin
            model_reset();
            evq.delete();
            m_live = 1;
        end else if (m_mode == 2) begin
            m_lock_left--;
            if (m_lock_left == 0) m_mode = 1;
        end else if (have_ev) begin
            model_key(ev.code);
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("state_o",        32'(state_o),        32'(m_mode));
            check("unlocked",       32'(unlocked),       32'(m_mode == 0));
            check("entry_digits",   32'(entry_digits),   m_value());
            check("entry_count",    32'(entry_count),    32'(m_digits.size()));
            check("fail_count",     32'(fail_count),     32'(m_fails));
            check("lockout_active", 32'(lockout_active), 32'(m_mode == 2));
            check("pass_ok",        32'(pass_ok),        32'(m_ok));
            check("pass_bad",       32'(pass_bad),       32'(m_bad));
            if (pass_ok)       n_ok_seen++;
            if (pass_bad)      n_bad_seen++;
            if (state_o == 2)  n_lock_seen++;
        end
    end

    // Raise valid for 'hold' sampled edges, then keep it low for at least 3.
    task automatic press(input logic [3:0] c, input int hold);
        ev_t e;
        @(negedge clk);
        key_code  = c;
        key_valid = 1'b1;
        e.due  = cyc + 3;
        e.code = c;
        evq.push_back(e);
        repeat (hold) @(negedge clk);
        key_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic key(input logic [3:0] c);
        press(c, int'($urandom_range(1, 4)));
    endtask

    task automatic enter_val(input logic [31:0] v, input int nd);
        for (int i = nd - 1; i >= 0; i--) key(4'((v >> (4 * i)) & 32'hF));
        key(4'hE);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int ok0, bad0, lk0, kind, len;
        logic [31:0] v;

        reset = 1'b1;
        key_valid = 1'b0;
        key_code = 4'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_state",    32'(state_o),        32'd0);
        check("rst_unlocked", 32'(unlocked),       32'd1);
        check("rst_count",    32'(entry_count),    32'd0);
        check("rst_lockout",  32'(lockout_active), 32'd0);

        // 1: first digit visible on the third edge after its valid rise
        @(negedge clk);
        key_code = 4'h1;
        key_valid = 1'b1;
        evq.push_back('{due: cyc + 3, code: 4'h1});
        @(negedge clk);
        @(negedge clk);
        check("t1_latency_pre", 32'(entry_count), 32'd0);
        @(negedge clk);
        check("t1_latency_post", 32'(entry_count), 32'd1);
        key_valid = 1'b0;
        repeat (3) @(negedge clk);
        press(4'h2, 1);
        press(4'h3, 2);
        press(4'h4, 1);
        check("t1_digits", 32'(entry_digits), 32'h1234);
        press(4'hE, 1);
        check("t1_state",    32'(state_o),     32'd1);
        check("t1_unlocked", 32'(unlocked),    32'd0);
        check("t1_count",    32'(entry_count), 32'd0);

        // 2: correct unlock
        ok0 = n_ok_seen;
        enter_val(32'h1234, 4);
        check("t2_ok_pulses", 32'(n_ok_seen - ok0), 32'd1);
        check("t2_state",     32'(state_o),         32'd0);
        check("t2_fails",     32'(fail_count),      32'd0);

        // 3: relock with the same password, then two wrong entries (one short)
        enter_val(32'h1234, 4);
        bad0 = n_bad_seen;
        enter_val(32'h9999, 4);
        enter_val(32'h1, 1);
        check("t3_bad_pulses", 32'(n_bad_seen - bad0), 32'd2);
        check("t3_fails",      32'(fail_count),        32'd2);
        check("t3_state",      32'(state_o),           32'd1);

        // 4: third wrong entry
        lk0 = n_lock_seen;
        enter_val(32'h5555, 4);
`ifdef VAULT_LOCKOUT_EN
        check("t4_state_lockout", 32'(state_o),        32'd2);
        check("t4_lockout_flag",  32'(lockout_active), 32'd1);
        press(4'h7, 1);
        press(4'h8, 2);
        check("t4_keys_ignored",  32'(entry_count),    32'd0);
        for (int g = 0; g < 100 && state_o == 2; g++) @(negedge clk);
        check("t4_lock_len",      32'(n_lock_seen - lk0), 32'd20);
        check("t4_state_after",   32'(state_o),        32'd1);
        check("t4_fails_after",   32'(fail_count),     32'd0);
`else
        check("t4_state",   32'(state_o),        32'd1);
        check("t4_fails",   32'(fail_count),     32'd3);
        check("t4_lockout", 32'(lockout_active), 32'd0);
        check("t4_no_lock", 32'(n_lock_seen - lk0), 32'd0);
`endif

        // 5: cancel, overflow digit, held key
        press(4'h0, 1);
        press(4'h0, 1);
        press(4'h5, 1);
        check("t5_count_pre_cancel", 32'(entry_count), 32'd3);
        press(4'hF, 1);
        check("t5_cancel_count", 32'(entry_count), 32'd0);
        check("t5_cancel_state", 32'(state_o),     32'd1);
        for (int i = 1; i <= 5; i++) press(4'(i), 1);
        check("t5_overflow_digits", 32'(entry_digits), 32'h1234);
        check("t5_overflow_count",  32'(entry_count),  32'd4);
        press(4'hF, 1);
        press(4'h6, 100);
        check("t5_hold_count",  32'(entry_count),  32'd1);
        check("t5_hold_digits", 32'(entry_digits), 32'h6);
        press(4'hF, 1);

`ifndef VAULT_LOCKOUT_EN
        // 6: fourth wrong entry keeps counting with no lockout
        enter_val(32'h1111, 4);
        check("t6_fails",   32'(fail_count),     32'd4);
        check("t6_state",   32'(state_o),        32'd1);
        check("t6_lockout", 32'(lockout_active), 32'd0);
`endif

        // random sessions
        for (int r = 0; r < 40; r++) begin
            kind = int'($urandom_range(0, 9));
            if (m_mode == 0) begin
                if (kind < 6) begin
                    enter_val(32'($urandom) & 32'h0000_DDDD, N);
                end else begin
                    len = int'($urandom_range(0, N - 1));
                    for (int i = 0; i < len; i++) key(4'($urandom_range(0, 13)));
                    key(4'hE);
                    key(4'hF);
                end
            end else begin
                if (kind < 4) begin
                    enter_val(m_pwd, N);
                end else if (kind < 8) begin
                    len = int'($urandom_range(0, N + 1));
                    for (int i = 0; i < len; i++) key(4'($urandom_range(0, 13)));
                    key(4'hE);
                end else begin
                    len = int'($urandom_range(1, N));
                    for (int i = 0; i < len; i++) key(4'($urandom_range(0, 13)));
                    key(4'hF);
                end
            end
            for (int g = 0; g < LOCK + 10 && m_mode == 2; g++) @(negedge clk);
        end

        // reset mid-entry
        press(4'h1, 1);
        press(4'h2, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst2_state",    32'(state_o),        32'd0);
        check("rst2_unlocked", 32'(unlocked),       32'd1);
        check("rst2_digits",   32'(entry_digits),   32'd0);
        check("rst2_count",    32'(entry_count),    32'd0);
        check("rst2_fails",    32'(fail_count),     32'd0);
        check("rst2_lockout",  32'(lockout_active), 32'd0);
        check("rst2_pulses",   32'({pass_ok, pass_bad}), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
